// File: rtl/nn_convnode_sched.sv
// Sequencer for one stochastic convolution node: per output position it clears the node,
// warms the streams up, counts a_out ones over STREAM_LEN cycles and hands the count downstream.
module nn_convnode_sched #(
  parameter int unsigned STREAM_LEN = 256,
  parameter int unsigned WARMUP     = 8,
  parameter int unsigned CLR_CYC    = 2,
  parameter int unsigned NUM_POS    = 4,
  parameter int unsigned POS_W      = 2,
  parameter int unsigned CNT_W      = 9
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             start,
  input  logic             abort,
  input  logic             a_out,
  input  logic             res_ready,
  output logic             busy,
  output logic [POS_W-1:0] pos_idx,
  output logic             node_init,
  output logic             a_mem_active,
  output logic             stream_en,
  output logic [CNT_W-1:0] res_data,
  output logic             res_valid,
  output logic             done
);

  // Phase counter shares the result width; every phase length is below 2^CNT_W.
  localparam int unsigned PhW = CNT_W;

  typedef enum logic [2:0] {StIdle, StClr, StWarm, StRun, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] res_data_q, res_data_d;
  logic             busy_q, busy_d;
  logic             node_init_q, node_init_d;
  logic             a_mem_active_q, a_mem_active_d;
  logic             stream_en_q, stream_en_d;
  logic             res_valid_q, res_valid_d;
  logic             done_q, done_d;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    ones_d     = ones_q;
    pos_d      = pos_q;
    res_data_d = res_data_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClr;
          phase_d = PhW'(CLR_CYC - 1);
          pos_d   = '0;
        end
      end
      StClr: begin
        ones_d = '0;
        if (phase_q == '0) begin
          state_d = StWarm;
          phase_d = PhW'(WARMUP - 1);
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      StWarm: begin
        if (phase_q == '0) begin
          state_d = StRun;
          phase_d = PhW'(STREAM_LEN - 1);
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      StRun: begin
        ones_d = ones_q + CNT_W'(a_out);
        if (phase_q == '0) begin
          // Result includes the final RUN cycle's bit.
          state_d    = StHold;
          res_data_d = ones_q + CNT_W'(a_out);
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      StHold: begin
        if (res_ready) begin
          if (pos_q == POS_W'(NUM_POS - 1)) begin
            state_d = StDone;
            pos_d   = '0;
          end else begin
            state_d = StClr;
            phase_d = PhW'(CLR_CYC - 1);
            pos_d   = pos_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort returns to idle but keeps the last result visible on res_data.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      phase_d = '0;
      ones_d  = '0;
      pos_d   = '0;
    end

    busy_d         = (state_d != StIdle);
    node_init_d    = (state_d == StClr);
    a_mem_active_d = (state_d == StWarm) || (state_d == StRun);
    stream_en_d    = (state_d == StWarm) || (state_d == StRun);
    res_valid_d    = (state_d == StHold);
    done_d         = (state_d == StDone);
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q        <= StIdle;
      phase_q        <= '0;
      ones_q         <= '0;
      pos_q          <= '0;
      res_data_q     <= '0;
      busy_q         <= 1'b0;
      node_init_q    <= 1'b0;
      a_mem_active_q <= 1'b0;
      stream_en_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      ones_q         <= ones_d;
      pos_q          <= pos_d;
      res_data_q     <= res_data_d;
      busy_q         <= busy_d;
      node_init_q    <= node_init_d;
      a_mem_active_q <= a_mem_active_d;
      stream_en_q    <= stream_en_d;
      res_valid_q    <= res_valid_d;
      done_q         <= done_d;
    end
  end

  assign busy         = busy_q;
  assign pos_idx      = pos_q;
  assign node_init    = node_init_q;
  assign a_mem_active = a_mem_active_q;
  assign stream_en    = stream_en_q;
  assign res_data     = res_data_q;
  assign res_valid    = res_valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_nn_convnode_sched.sv
// Directed self-checking bench for nn_convnode_sched at default parameters.
module tb_nn_convnode_sched;

  logic       CLK = 1'b0;
  logic       INIT = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       a_out = 1'b0;
  logic       res_ready = 1'b1;
  logic       busy;
  logic [1:0] pos_idx;
  logic       node_init;
  logic       a_mem_active;
  logic       stream_en;
  logic [8:0] res_data;
  logic       res_valid;
  logic       done;

  int checks = 0;
  int errors = 0;

  int n_res;
  int done_cyc;
  int ni_cnt;
  int res_arr[8];
  int pidx_arr[8];

  nn_convnode_sched dut (
    .CLK          (CLK),
    .INIT         (INIT),
    .start        (start),
    .abort        (abort),
    .a_out        (a_out),
    .res_ready    (res_ready),
    .busy         (busy),
    .pos_idx      (pos_idx),
    .node_init    (node_init),
    .a_mem_active (a_mem_active),
    .stream_en    (stream_en),
    .res_data     (res_data),
    .res_valid    (res_valid),
    .done         (done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_pos_idx"}, pos_idx, 0);
    chk({pfx, "_node_init"}, node_init, 0);
    chk({pfx, "_a_mem_active"}, a_mem_active, 0);
    chk({pfx, "_stream_en"}, stream_en, 0);
    chk({pfx, "_res_data"}, res_data, 0);
    chk({pfx, "_res_valid"}, res_valid, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  // Called at a negedge. Position-local cycle: 1-2 CLR, 3-10 WARM, 11-266 RUN, 267+ HOLD.
  // mode 0: a_out=1; mode 1: toggle from 1 in first RUN cycle; mode 2: 1 except 0 in RUN.
  task automatic run_frame(input int mode, input bit bp, input bit start_busy);
    int cyc, loc, bp_left;
    bit prev_ni, bp_done, chk_next;
    n_res = 0; done_cyc = -1; ni_cnt = 0;
    cyc = 0; loc = 0; bp_left = 0; prev_ni = 0; bp_done = 0; chk_next = 0;
    res_ready = 1'b1;
    start = 1'b1;
    while (cyc < 1200) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        chk("first_clr_node_init", node_init, 1);
        chk("first_clr_busy", busy, 1);
        chk("first_clr_pos", pos_idx, 0);
      end
      start = start_busy && (cyc == 100);
      if (chk_next) begin
        chk("bp_then_clr_node_init", node_init, 1);
        chk("bp_then_clr_pos", pos_idx, 2);
        chk_next = 0;
      end
      if (node_init && !prev_ni) loc = 1;
      else loc++;
      prev_ni = node_init;
      if (node_init) ni_cnt++;
      case (mode)
        1:       a_out = (loc >= 11 && loc <= 266) ? ((loc - 11) % 2 == 0) : 1'b1;
        2:       a_out = (loc >= 11 && loc <= 266) ? 1'b0 : 1'b1;
        default: a_out = 1'b1;
      endcase
      if (bp && res_valid && pos_idx == 2'd1 && !bp_done) begin
        bp_left = 10;
        bp_done = 1;
      end
      if (bp_left > 0) begin
        res_ready = 1'b0;
        chk("bp_res_valid", res_valid, 1);
        chk("bp_res_data", res_data, 256);
        chk("bp_pos_idx", pos_idx, 1);
        chk("bp_stream_en", stream_en, 0);
        bp_left--;
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        if (n_res < 8) begin
          res_arr[n_res]  = int'(res_data);
          pidx_arr[n_res] = int'(pos_idx);
        end
        n_res++;
        if (bp && pos_idx == 2'd1) chk_next = 1;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    a_out = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int exp_val, input int exp_done);
    chk({nm, "_num_results"}, n_res, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_res_data_%0d", nm, i), res_arr[i], exp_val);
      chk($sformatf("%s_res_pos_%0d", nm, i), pidx_arr[i], i);
    end
    chk({nm, "_done_cycle"}, done_cyc, exp_done);
    chk({nm, "_node_init_cycles"}, ni_cnt, 8);
    @(negedge CLK);
    chk({nm, "_after_done"}, done, 0);
    chk({nm, "_after_busy"}, busy, 0);
    chk({nm, "_after_pos"}, pos_idx, 0);
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 8; i++) begin
      res_arr[i]  = -1;
      pidx_arr[i] = -1;
    end

    // Reset
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    INIT = 1'b0;

    // Frame with a_out=1 and a stray start while busy
    run_frame(0, 1'b0, 1'b1);
    check_frame("ones", 256, 1069);

    // Toggling stream: half ones
    run_frame(1, 1'b0, 1'b0);
    check_frame("toggle", 128, 1069);

    // Ones only outside RUN: warm-up excluded
    run_frame(2, 1'b0, 1'b0);
    check_frame("warm_only", 0, 1069);

    // Backpressure at position 1 for 10 cycles
    run_frame(0, 1'b1, 1'b0);
    check_frame("backpressure", 256, 1079);

    // INIT asserted mid-RUN
    start = 1'b1;
    a_out = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (49) @(negedge CLK);
    chk("midrun_stream_en", stream_en, 1);
    INIT = 1'b1;
    @(negedge CLK);
    chk_all_zero("init_midrun");
    INIT = 1'b0;

    // Abort while holding the first result
    res_ready = 1'b0;
    start = 1'b1;
    waited = 0;
    @(negedge CLK);
    start = 1'b0;
    while (!res_valid && waited < 400) begin
      @(negedge CLK);
      waited++;
    end
    chk("abort_reached_hold", res_valid, 1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    res_ready = 1'b1;
    a_out = 1'b0;
    chk("abort_res_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_res_data_kept", res_data, 256);
    chk("abort_pos", pos_idx, 0);
    chk("abort_stream_en", stream_en, 0);
    for (int i = 0; i < 20; i++) begin
      chk("abort_no_done", done, 0);
      chk("abort_stays_idle", busy, 0);
      @(negedge CLK);
    end

    // Fresh frame after abort
    run_frame(1, 1'b0, 1'b0);
    check_frame("after_abort", 128, 1069);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
